lvds_tx_framer: RTL and testbench

- Upstream feeder for the 4-channel 6x LVDS transmitter.
- Accepts 24-bit payload words on a valid/ready stream and buffers them in a small FIFO.
- Emits one 24-bit tx_data word per clk50 cycle, built as two-cycle frames: clock lane, two data lanes and a control/sync lane.
- Sends an idle frame when no payload is available, so the serial link never stalls.

---
 rtl/lvds_tx_framer.sv | 152 +++++++++++++++
 tb/tb_lvds_tx_framer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lvds_tx_framer.sv
// lvds_tx_framer: payload FIFO plus two-cycle frame builder feeding a
// 4-channel 6x LVDS transmitter. Each frame carries a clock lane, two data
// lanes and a control/sync lane; an idle frame goes out whenever the FIFO is
// empty so the serial link never stalls.
// Optional feature: define LVDS_TX_TESTPAT_EN to add the test_mode input,
// which replaces payload with a 16-bit incrementing test pattern.
module lvds_tx_framer #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEVEL_W    = 4
) (
    input  logic               clk50,
    input  logic               reset,
`ifdef LVDS_TX_TESTPAT_EN
    input  logic               test_mode,
`endif
    input  logic               in_valid,
    input  logic [23:0]        in_data,
    output logic               in_ready,
    output logic [23:0]        tx_data,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic [15:0]        idle_frames
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // First half of a frame carries sync and the low payload half; second
    // half carries the control word and the high payload half.
    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } phase_t;

    logic [23:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LEVEL_W-1:0] r_count;
    phase_t             r_phase;
    logic [23:0]        r_w;
    logic               r_fv;
    logic [2:0]         r_seq;
    logic [15:0]        r_idle;
    logic [23:0]        r_tx;

    logic               w_tm;
    logic [15:0]        w_tp;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [23:0]        w_next_w;
    logic               w_next_fv;

`ifdef LVDS_TX_TESTPAT_EN
    logic [15:0]        r_tp;

    // Test-pattern counter advances once per frame while test mode is on.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_tp <= '0;
        end else if (test_mode && r_phase == PH_FIRST) begin
            r_tp <= r_tp + 16'd1;
        end
    end

    assign w_tm = test_mode;
    assign w_tp = r_tp;
`else
    assign w_tm = 1'b0;
    assign w_tp = '0;
`endif

    assign w_full   = (r_count == LEVEL_W'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    // Ready depends only on the registered count, so a pop on a full FIFO
    // cannot open room for a push on the same edge.
    assign in_ready = !reset && !w_full && !w_tm;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_phase == PH_FIRST) && !w_empty && !w_tm;

    // Select the word for the next frame: test pattern, FIFO head, or idle.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        w_next_w  = '0;
        w_next_fv = 1'b0;
        if (w_tm) begin
            w_next_w  = {8'h00, w_tp};
            w_next_fv = 1'b1;
        end else if (!w_empty) begin
            w_next_w  = r_mem[r_rd_ptr];
            w_next_fv = 1'b1;
        end
    end

    // Payload storage write port.
    // NOTE: memory is left unreset; the pointers and count define what is valid.
    always_ff @(posedge clk50) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO bookkeeping, frame phase, frame build, sequence and idle counters.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_phase  <= PH_FIRST;
            r_w      <= '0;
            r_fv     <= 1'b0;
            r_seq    <= '0;
            r_idle   <= '0;
            r_tx     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case (r_phase)
                PH_FIRST: begin
                    r_phase <= PH_SECOND;
                    r_w     <= w_next_w;
                    r_fv    <= w_next_fv;
                    r_tx    <= {w_next_w[11:6], 6'b001000, w_next_w[5:0], 6'b111100};
                    if (!w_next_fv && r_idle != 16'hFFFF) begin
                        r_idle <= r_idle + 16'd1;
                    end
                end
                default: begin
                    r_phase <= PH_FIRST;
                    r_tx    <= {r_w[23:18], r_fv, 2'b00, r_seq, r_w[17:12], 6'b000000};
                    if (r_fv) begin
                        r_seq <= r_seq + 3'd1;
                    end
                end
            endcase
        end
    end

    assign tx_data     = r_tx;
    assign fifo_level  = r_count;
    assign idle_frames = r_idle;

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Testbench for lvds_tx_framer: randomized stimulus against a queue-based
// reference model; expected words go through a scoreboard that a separate
// monitor drains and compares on every non-reset clock edge.
module tb_lvds_tx_framer;

    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clk50 = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [23:0]   in_data = '0;
    logic          in_ready;
    logic [23:0]   tx_data;
    logic [LW-1:0] fifo_level;
    logic [15:0]   idle_frames;
`ifdef LVDS_TX_TESTPAT_EN
    logic          test_mode = 1'b0;
`endif

    lvds_tx_framer #(.FIFO_DEPTH(DEPTH), .LEVEL_W(LW)) dut (
        .clk50       (clk50),
        .reset       (reset),
`ifdef LVDS_TX_TESTPAT_EN
        .test_mode   (test_mode),
`endif
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .tx_data     (tx_data),
        .fifo_level  (fifo_level),
        .idle_frames (idle_frames)
    );

    always #10 clk50 = ~clk50;

    typedef struct {
        logic [23:0] tx;
        int          level;
        int          idle;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] m_q[$];
    bit          m_phase;
    logic [23:0] m_w;
    bit          m_fv;
    int          m_seq;
    int          m_idle;
    logic [15:0] m_tp;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        sb.delete();
        m_phase = 1'b0;
        m_w     = '0;
        m_fv    = 1'b0;
        m_seq   = 0;
        m_idle  = 0;
        m_tp    = '0;
    endfunction

    // One clock edge of the framer, described as frames built from a queue.
    function automatic void model_edge(input bit v, input logic [23:0] d, input bit tm);
        bit   acc;
        exp_t e;
        acc = v && !tm && (m_q.size() < DEPTH);
        if (!m_phase) begin
            if (tm) begin
                m_w  = {8'h00, m_tp};
                m_fv = 1'b1;
                m_tp = m_tp + 16'd1;
            end else if (m_q.size() > 0) begin
                m_w  = m_q.pop_front();
                m_fv = 1'b1;
            end else begin
                m_w  = '0;
                m_fv = 1'b0;
                if (m_idle < 65535) m_idle++;
            end
            e.tx = {m_w[11:6], 6'b001000, m_w[5:0], 6'b111100};
        end else begin
            e.tx = {m_w[23:18], m_fv, 2'b00, 3'(m_seq), m_w[17:12], 6'b000000};
            if (m_fv) m_seq = (m_seq + 1) % 8;
        end
        if (acc) m_q.push_back(d);
        m_phase = !m_phase;
        e.level = m_q.size();
        e.idle  = m_idle;
        sb.push_back(e);
    endfunction

    // Called at a falling edge: applies inputs for the next rising edge.
    task automatic drive(input bit v, input logic [23:0] d, input bit tm = 1'b0);
`ifdef LVDS_TX_TESTPAT_EN
        test_mode = tm;
`endif
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, (!tm && m_q.size() < DEPTH)});
        in_valid = v;
        in_data  = d;
        model_edge(v, d, tm);
        @(negedge clk50);
    endtask

    // Monitor: every rising edge out of reset must match the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk50);
            #1;
            if (!reset) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL scoreboard_empty at %0t: got no expected entry, required one", $time);
                end else begin
                    e = sb.pop_front();
                    check("tx_data", {8'd0, tx_data}, {8'd0, e.tx});
                    check("fifo_level", {28'd0, fifo_level}, e.level);
                    check("idle_frames", {16'd0, idle_frames}, e.idle);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk50);
        #1;
        check("rst_tx_data", {8'd0, tx_data}, 32'd0);
        check("rst_level", {28'd0, fifo_level}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_idle", {16'd0, idle_frames}, 32'd0);
        @(negedge clk50);
        reset = 1'b0;

        // Idle link.
        repeat (8) drive(1'b0, '0);

        // Single word.
        drive(1'b1, 24'hABCDEF);
        repeat (6) drive(1'b0, '0);

        // Push every cycle: FIFO fills and backpressures.
        repeat (20) drive(1'b1, 24'($urandom()));
        repeat (20) drive(1'b0, '0);

        // Push at phase 1 into empty, then push on the phase-0 pop edge.
        while (m_phase != 1'b1) drive(1'b0, '0);
        drive(1'b1, 24'($urandom()));
        drive(1'b1, 24'($urandom()));
        check("level_same_edge", {28'd0, fifo_level}, 32'd1);
        repeat (6) drive(1'b0, '0);

        // Random traffic at moderate and high rates.
        repeat (300) drive($urandom_range(0, 99) < 45, 24'($urandom()));
        repeat (200) drive($urandom_range(0, 99) < 75, 24'($urandom()));
        repeat (20) drive(1'b0, '0);

        // Reset in the middle of traffic with five words buffered.
        for (int i = 0; i < 40 && m_q.size() < 5; i++) drive(1'b1, 24'($urandom()));
        check("level_before_reset", {28'd0, fifo_level}, 32'd5);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_tx_data", {8'd0, tx_data}, 32'd0);
        check("midrst_level", {28'd0, fifo_level}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_idle", {16'd0, idle_frames}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk50);
        reset = 1'b0;
        drive(1'b0, '0);
        check("first_frame_idle", {8'd0, tx_data}, 32'h0000_803C);
        repeat (40) drive($urandom_range(0, 99) < 50, 24'($urandom()));

`ifdef LVDS_TX_TESTPAT_EN
        // Test pattern with words left in the FIFO; level must stay frozen.
        repeat (6) drive(1'b1, 24'($urandom()));
        repeat (16) drive($urandom_range(0, 1) == 1, 24'($urandom()), 1'b1);
        repeat (20) drive(1'b0, '0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
